// File: rtl/act_grad_stream.sv
// act_grad_stream: streaming activation-gradient unit, grad = g * f'(x).
// Two register stages: S1 picks the derivative slope for the selected
// activation, S2 multiplies, floors back to the fixed-point format and
// saturates. Both stages advance together under a single stall signal.
module act_grad_stream #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_func,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_g,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_grad,
    output logic              out_sat,
    output logic [CNT_W-1:0]  sat_count
);

    localparam int ONE = 1 << FRAC_W;
    localparam int PW  = 2 * DATA_W;

    // Slope values in the data format
    localparam logic signed [DATA_W-1:0] SLOPE_ONE  = DATA_W'(ONE);
    localparam logic signed [DATA_W-1:0] SLOPE_HALF = DATA_W'(ONE / 2);
    localparam logic signed [DATA_W-1:0] SLOPE_QTR  = DATA_W'(ONE / 4);

    // Segment boundaries, one bit wider so |x| of the most negative x fits
    localparam logic signed [DATA_W:0] B_QTR     = (DATA_W+1)'(ONE / 4);
    localparam logic signed [DATA_W:0] B_3QTR    = (DATA_W+1)'(3 * ONE / 4);
    localparam logic signed [DATA_W:0] B_SIG_POS = (DATA_W+1)'(2 * ONE);
    localparam logic signed [DATA_W:0] B_SIG_NEG = (DATA_W+1)'(-2 * ONE);

    // Clip limits expressed at product width
    localparam logic signed [PW-1:0] R_MAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0] R_MIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic                     advance;
    logic                     s1_valid_reg;
    logic signed [DATA_W-1:0] s1_slope_reg;
    logic signed [DATA_W-1:0] s1_g_reg;
    logic signed [DATA_W-1:0] slope_next;
    logic signed [DATA_W:0]   x_ext;
    logic signed [DATA_W:0]   x_abs;
    logic                     out_valid_reg;
    logic [DATA_W-1:0]        out_grad_reg;
    logic                     out_sat_reg;
    logic [DATA_W-1:0]        grad_next;
    logic                     sat_next;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     prod_shr;
    logic [CNT_W-1:0]         sat_count_reg;

    // The whole pipe moves whenever the output register is free or draining
    assign advance  = !out_valid_reg || out_ready;
    assign in_ready = advance;

    // S1 slope selection; boundaries are compared on a sign-extended x
    always_comb begin
        x_ext      = {in_x[DATA_W-1], in_x};
        x_abs      = x_ext[DATA_W] ? -x_ext : x_ext;
        slope_next = SLOPE_ONE;
        case (in_func)
            2'b00: slope_next = (x_ext > 0) ? SLOPE_ONE : $signed(in_a);
            2'b01: slope_next = (x_ext >= B_SIG_NEG && x_ext <= B_SIG_POS) ? SLOPE_QTR : '0;
            2'b10: begin
                if (x_abs <= B_QTR)
                    slope_next = SLOPE_ONE;
                else if (x_abs < B_3QTR)
                    slope_next = SLOPE_HALF;
                else
                    slope_next = '0;
            end
            default: slope_next = SLOPE_ONE;
        endcase
    end

    // S1 register: slope, gradient and valid
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_slope_reg <= '0;
            s1_g_reg     <= '0;
        end else if (advance) begin
            s1_valid_reg <= in_valid;
            s1_slope_reg <= slope_next;
            s1_g_reg     <= $signed(in_g);
        end
    end

    // S2 arithmetic: full product, floor shift, clip to the data range
    always_comb begin
        prod     = PW'(s1_g_reg) * PW'(s1_slope_reg);
        prod_shr = prod >>> FRAC_W;
        sat_next = 1'b0;
        if (prod_shr > R_MAX) begin
            grad_next = OUT_MAX;
            sat_next  = 1'b1;
        end else if (prod_shr < R_MIN) begin
            grad_next = OUT_MIN;
            sat_next  = 1'b1;
        end else begin
            grad_next = prod_shr[DATA_W-1:0];
        end
    end

    // S2 register: output beat, held while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_grad_reg  <= '0;
            out_sat_reg   <= 1'b0;
        end else if (advance) begin
            out_valid_reg <= s1_valid_reg;
            out_grad_reg  <= grad_next;
            out_sat_reg   <= sat_next;
        end
    end

    // Count clipped beats as they leave; stick at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count_reg <= '0;
        end else if (out_valid_reg && out_ready && out_sat_reg && (sat_count_reg != '1)) begin
            sat_count_reg <= sat_count_reg + 1'b1;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_grad  = out_grad_reg;
    assign out_sat   = out_sat_reg;
    assign sat_count = sat_count_reg;

endmodule

// File: tb/tb_act_grad_stream.sv
// Bench for act_grad_stream: directed vector table, backpressure and
// mid-stream reset sequences, then random traffic against a reference model.
module tb_act_grad_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_func;
    logic [15:0] in_x;
    logic [15:0] in_a;
    logic [15:0] in_g;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_grad;
    logic        out_sat;
    logic [15:0] sat_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    act_grad_stream #(.DATA_W(16), .FRAC_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_func(in_func), .in_x(in_x), .in_a(in_a), .in_g(in_g),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_grad(out_grad), .out_sat(out_sat), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  func;
        logic [15:0] x;
        logic [15:0] a;
        logic [15:0] g;
        logic [15:0] grad;
        logic        sat;
    } vec_t;

    typedef struct {
        logic [15:0] grad;
        logic        sat;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: derivative slope from the segment rules, then floor(g*s/ONE) clipped
    function automatic exp_t model(input logic [1:0] f, input logic [15:0] x,
                                   input logic [15:0] a, input logic [15:0] g);
        exp_t   e;
        int     xi, ai, gv, s, ax;
        longint p, r;
        xi = int'($signed(x));
        ai = int'($signed(a));
        gv = int'($signed(g));
        ax = (xi < 0) ? -xi : xi;
        case (f)
            2'd0: s = (xi > 0) ? 256 : ai;
            2'd1: s = (xi >= -512 && xi <= 512) ? 64 : 0;
            2'd2: s = (ax <= 64) ? 256 : ((ax < 192) ? 128 : 0);
            default: s = 256;
        endcase
        p = longint'(gv) * longint'(s);
        r = p / 256;
        if ((p % 256 != 0) && (p < 0)) r = r - 1;
        e.sat = 1'b0;
        if (r > 32767) begin
            r = 32767; e.sat = 1'b1;
        end else if (r < -32768) begin
            r = -32768; e.sat = 1'b1;
        end
        e.grad = 16'(r);
        return e;
    endfunction

    logic        hold_pending = 1'b0;
    logic [15:0] hold_grad;
    logic        hold_sat;

    // One random-traffic cycle: drive, settle, score handshakes, then clock
    task automatic rand_step(input bit drive);
        int   bl[17] = '{0, 64, 65, 191, 192, -64, -65, -191, -192,
                         512, 513, -512, -513, 1, -1, -32768, 32767};
        exp_t e;
        in_valid  = drive ? ($urandom_range(0, 3) != 0) : 1'b0;
        in_func   = 2'($urandom_range(0, 3));
        in_x      = ($urandom_range(0, 1) == 0) ? 16'(bl[$urandom_range(0, 16)]) : 16'($urandom);
        in_a      = 16'($urandom);
        in_g      = 16'($urandom);
        out_ready = drive ? ($urandom_range(0, 2) != 0) : 1'b1;
        #1;
        if (hold_pending) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_grad", 32'(out_grad), 32'(hold_grad));
            check("stall_sat", 32'(out_sat), 32'(hold_sat));
        end
        hold_pending = out_valid && !out_ready;
        hold_grad    = out_grad;
        hold_sat     = out_sat;
        if (in_valid && in_ready) sb.push_back(model(in_func, in_x, in_a, in_g));
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("rand_unexpected_beat", 32'(out_grad), 32'hDEAD_BEEF);
            end else begin
                e = sb.pop_front();
                check("rand_grad", 32'(out_grad), 32'(e.grad));
                check("rand_sat", 32'(out_sat), 32'(e.sat));
                if (e.sat && exp_cnt < 65535) exp_cnt++;
            end
        end
        tick();
        check("rand_sat_count", 32'(sat_count), 32'(exp_cnt));
    endtask

    vec_t vt[$];

    initial begin
        int   sent, stall_left, got_n;
        bit   seen_first, stale;
        int   got[$];

        rst = 1'b1; in_valid = 1'b0; in_func = 2'd0; in_x = '0; in_a = '0; in_g = '0;
        out_ready = 1'b1;
        tick(); tick(); tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_grad", 32'(out_grad), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        check("rst_sat_count", 32'(sat_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        tick();

        // func, x, a, g, expected grad, expected sat
        vt.push_back('{2'd2, 16'h0020, 16'h0000, 16'h0100, 16'h0100, 1'b0});
        vt.push_back('{2'd2, 16'h0040, 16'h0000, 16'h0100, 16'h0100, 1'b0});
        vt.push_back('{2'd2, 16'h0080, 16'h0000, 16'h0100, 16'h0080, 1'b0});
        vt.push_back('{2'd2, 16'h00C0, 16'h0000, 16'h0100, 16'h0000, 1'b0});
        vt.push_back('{2'd2, 16'hFF40, 16'h0000, 16'h0100, 16'h0000, 1'b0});
        vt.push_back('{2'd2, 16'hFFC0, 16'h0000, 16'h0100, 16'h0100, 1'b0});
        vt.push_back('{2'd2, 16'h0080, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0});
        vt.push_back('{2'd1, 16'h0000, 16'h0000, 16'h0400, 16'h0100, 1'b0});
        vt.push_back('{2'd1, 16'h0200, 16'h0000, 16'h0400, 16'h0100, 1'b0});
        vt.push_back('{2'd1, 16'h0201, 16'h0000, 16'h0400, 16'h0000, 1'b0});
        vt.push_back('{2'd1, 16'hFE00, 16'h0000, 16'h0400, 16'h0100, 1'b0});
        vt.push_back('{2'd1, 16'hFDFF, 16'h0000, 16'h0400, 16'h0000, 1'b0});
        vt.push_back('{2'd0, 16'hFF00, 16'h0033, 16'h0200, 16'h0066, 1'b0});
        vt.push_back('{2'd0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0});
        vt.push_back('{2'd0, 16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1});
        vt.push_back('{2'd3, 16'h1234, 16'h0000, 16'h8000, 16'h8000, 1'b0});

        foreach (vt[i]) begin
            in_func = vt[i].func; in_x = vt[i].x; in_a = vt[i].a; in_g = vt[i].g;
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            check("vec_in_ready", 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            check("vec_lat1_valid", 32'(out_valid), 32'd0);
            tick();
            check("vec_lat2_valid", 32'(out_valid), 32'd1);
            check("vec_grad", 32'(out_grad), 32'(vt[i].grad));
            check("vec_sat", 32'(out_sat), 32'(vt[i].sat));
            tick();
            if (vt[i].sat) exp_cnt++;
            check("vec_sat_count", 32'(sat_count), 32'(exp_cnt));
            $display("vec %0d func=%0d x=%h a=%h g=%h grad=%h sat=%0d cnt=%0d",
                     i, vt[i].func, vt[i].x, vt[i].a, vt[i].g, out_grad, out_sat, sat_count);
        end

        // Backpressure: 5 identity beats, 4-cycle stall on the first output
        sent = 0; stall_left = 4; seen_first = 1'b0;
        for (int c = 0; c < 40 && got.size() < 5; c++) begin
            in_func = 2'd3; in_x = '0; in_a = '0;
            in_valid = (sent < 5);
            in_g = 16'(sent + 1);
            if (out_valid && !seen_first) seen_first = 1'b1;
            out_ready = !(seen_first && stall_left > 0);
            #1;
            if (!out_ready) begin
                check("bp_stall_in_ready", 32'(in_ready), 32'd0);
                check("bp_stall_grad", 32'(out_grad), 32'd1);
                stall_left--;
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                got.push_back(int'(out_grad));
                $display("bp beat grad=%0d", out_grad);
            end
            tick();
        end
        got_n = got.size();
        check("bp_count", 32'(got_n), 32'd5);
        for (int k = 0; k < got_n; k++) check("bp_order", 32'(got[k]), 32'(k + 1));
        in_valid = 1'b0;
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Random traffic with random backpressure, then drain
        for (int c = 0; c < 600; c++) rand_step(1'b1);
        for (int c = 0; c < 8; c++) rand_step(1'b0);
        check("rand_scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("random phase done sat_count=%0d", sat_count);

        // Reset with two beats in flight
        in_func = 2'd0; in_x = 16'hFFFF; in_a = 16'h7FFF; in_g = 16'h7FFF;
        in_valid = 1'b1; out_ready = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        check("mid_inflight_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sat_count", 32'(sat_count), 32'd0);
        check("mid_rst_grad", 32'(out_grad), 32'd0);
        rst = 1'b0;
        stale = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid) stale = 1'b1;
        end
        check("mid_no_stale_beat", 32'(stale), 32'd0);
        check("mid_sat_count_after", 32'(sat_count), 32'd0);
        $display("mid-stream reset sequence done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
